// File: rtl/cle_label_reader_pkg.sv
// Shared types and constants for the component-label reader.
// Holds the image geometry, field widths, FSM state encoding, the per-object
// table entry struct and small coordinate min/max helpers.
package cle_pkg;

    localparam int IMG_W   = 32;
    localparam int ADDR_W  = 10;
    localparam int LABEL_W = 8;
    localparam int AREA_W  = 11;
    localparam int COORD_W = 5;
    localparam int MAX_OBJ = 8;
    localparam int CNT_W   = 4;
    localparam int IDX_W   = 3;
    localparam int NUM_PIX = IMG_W * IMG_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EMIT = 2'd2,
        FIN  = 2'd3
    } state_t;

    typedef struct packed {
        logic [LABEL_W-1:0] label;
        logic [AREA_W-1:0]  area;
        logic [COORD_W-1:0] row_min;
        logic [COORD_W-1:0] row_max;
        logic [COORD_W-1:0] col_min;
        logic [COORD_W-1:0] col_max;
        logic               vld;
    } obj_entry_t;

    function automatic logic [COORD_W-1:0] minCoord(input logic [COORD_W-1:0] a,
                                                    input logic [COORD_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [COORD_W-1:0] maxCoord(input logic [COORD_W-1:0] a,
                                                    input logic [COORD_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cle_label_reader_if.sv
// Bus bundle for the label reader: the read-only SRAM port plus the result
// valid/ready stream.
//   master : the reader (drives sram_a/wen/d and res_*, takes sram_q, res_ready)
//   slave  : the SRAM + result consumer side
interface cle_label_reader_if;
    import cle_pkg::*;

    logic [LABEL_W-1:0] sram_q;
    logic [ADDR_W-1:0]  sram_a;
    logic               sram_wen;
    logic [LABEL_W-1:0] sram_d;

    logic               res_valid;
    logic               res_ready;
    logic [LABEL_W-1:0] res_label;
    logic [AREA_W-1:0]  res_area;
    logic [COORD_W-1:0] res_row_min;
    logic [COORD_W-1:0] res_row_max;
    logic [COORD_W-1:0] res_col_min;
    logic [COORD_W-1:0] res_col_max;

    modport master (
        input  sram_q, res_ready,
        output sram_a, sram_wen, sram_d,
        output res_valid, res_label, res_area,
        output res_row_min, res_row_max, res_col_min, res_col_max
    );

    modport slave (
        output sram_q, res_ready,
        input  sram_a, sram_wen, sram_d,
        input  res_valid, res_label, res_area,
        input  res_row_min, res_row_max, res_col_min, res_col_max
    );

endinterface

// File: rtl/cle_label_reader_table.sv
// Object table for the label reader: up to MAX_OBJ distinct nonzero labels,
// each with area and bounding box, kept in first-seen order.
//   clear           : wipe table, count and overflow (scan start)
//   pixVld/pixLabel : one SRAM pixel with its row/col
//   rdIdx/rdEntry   : read port used while streaming results
//   count/countNext : entries allocated now / after this cycle's pixel
//   overflow        : a new label arrived while the table was full
module cle_label_table
    import cle_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               pixVld,
    input  logic [LABEL_W-1:0] pixLabel,
    input  logic [COORD_W-1:0] pixRow,
    input  logic [COORD_W-1:0] pixCol,
    input  logic [IDX_W-1:0]   rdIdx,
    output obj_entry_t         rdEntry,
    output logic [CNT_W-1:0]   count,
    output logic [CNT_W-1:0]   countNext,
    output logic               overflow
);

    obj_entry_t           table_q [MAX_OBJ];
    obj_entry_t           table_d [MAX_OBJ];
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 overflow_q, overflow_d;
    logic [MAX_OBJ-1:0]   hit;
    logic                 anyHit;
    logic                 full;

    // Labels in the table are distinct, so at most one hit bit is ever set.
    always_comb begin
        hit = '0;
        for (int i = 0; i < MAX_OBJ; i++) begin
            hit[i] = table_q[i].vld && (table_q[i].label == pixLabel);
        end
    end

    assign anyHit = |hit;
    assign full   = (count_q == CNT_W'(MAX_OBJ));

    // Pixels arrive in raster order, so a hit never lowers row_min and the
    // latest row is always the new row_max.
    always_comb begin
        table_d    = table_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (clear) begin
            for (int i = 0; i < MAX_OBJ; i++) begin
                table_d[i] = '0;
            end
            count_d    = '0;
            overflow_d = 1'b0;
        end else if (pixVld && (pixLabel != '0)) begin
            if (anyHit) begin
                for (int i = 0; i < MAX_OBJ; i++) begin
                    if (hit[i]) begin
                        table_d[i].area    = table_q[i].area + AREA_W'(1);
                        table_d[i].row_max = pixRow;
                        table_d[i].col_min = minCoord(table_q[i].col_min, pixCol);
                        table_d[i].col_max = maxCoord(table_q[i].col_max, pixCol);
                    end
                end
            end else if (full) begin
                overflow_d = 1'b1;
            end else begin
                for (int i = 0; i < MAX_OBJ; i++) begin
                    if (CNT_W'(i) == count_q) begin
                        table_d[i].label   = pixLabel;
                        table_d[i].area    = AREA_W'(1);
                        table_d[i].row_min = pixRow;
                        table_d[i].row_max = pixRow;
                        table_d[i].col_min = pixCol;
                        table_d[i].col_max = pixCol;
                        table_d[i].vld     = 1'b1;
                    end
                end
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MAX_OBJ; i++) begin
                table_q[i] <= '0;
            end
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            table_q    <= table_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign rdEntry   = table_q[rdIdx];
    assign count     = count_q;
    assign countNext = count_d;
    assign overflow  = overflow_q;

endmodule

// File: rtl/cle_label_reader.sv
// Raster-scan reader of the 1024-entry label SRAM. On start it reads every
// address once, builds the object table, then streams one record per object
// over the valid/ready port and pulses done.
//   clk, reset (async, active-low)
//   start     : scan request, honoured only in IDLE
//   busy/done : busy from start acceptance through the done pulse
//   obj_count/overflow : table statistics from the last scan
//   bus       : SRAM read port and result stream (master side)
module cle_label_reader
    import cle_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      obj_count,
    output logic                  overflow,
    cle_label_reader_if.master    bus
);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                lastIssued_q, lastIssued_d;
    logic [IDX_W-1:0]    emitPtr_q, emitPtr_d;
    logic                p1Vld_q;
    logic [ADDR_W-1:0]   p1Addr_q;
    logic                issue;
    logic                clearTbl;
    logic                pixVld;
    obj_entry_t          rdEntry;
    logic [CNT_W-1:0]    tblCount, tblCountNext;
    logic                tblOverflow;
    logic                emitOn;

    assign issue  = (state_q == SCAN) && !lastIssued_q;
    assign pixVld = (state_q == SCAN) && p1Vld_q;

    cle_label_table u_table (
        .clk       (clk),
        .reset     (reset),
        .clear     (clearTbl),
        .pixVld    (pixVld),
        .pixLabel  (bus.sram_q),
        .pixRow    (p1Addr_q[ADDR_W-1:COORD_W]),
        .pixCol    (p1Addr_q[COORD_W-1:0]),
        .rdIdx     (emitPtr_q),
        .rdEntry   (rdEntry),
        .count     (tblCount),
        .countNext (tblCountNext),
        .overflow  (tblOverflow)
    );

    // The SRAM returns data one cycle after the address, so the issued
    // address is delayed one stage to tag the returning pixel.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p1Vld_q  <= 1'b0;
            p1Addr_q <= '0;
        end else begin
            p1Vld_q  <= issue;
            p1Addr_q <= addr_q;
        end
    end

    // The scan ends when the pixel tagged with the last address is
    // processed; countNext includes that final pixel's allocation.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        lastIssued_d = lastIssued_q;
        emitPtr_d    = emitPtr_q;
        clearTbl     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    clearTbl     = 1'b1;
                    addr_d       = '0;
                    lastIssued_d = 1'b0;
                    emitPtr_d    = '0;
                    state_d      = SCAN;
                end
            end
            SCAN: begin
                if (issue) begin
                    if (addr_q == ADDR_W'(NUM_PIX - 1)) begin
                        lastIssued_d = 1'b1;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
                if (p1Vld_q && (p1Addr_q == ADDR_W'(NUM_PIX - 1))) begin
                    state_d = (tblCountNext != '0) ? EMIT : FIN;
                end
            end
            EMIT: begin
                if (bus.res_ready) begin
                    if (CNT_W'(emitPtr_q) == tblCount - CNT_W'(1)) begin
                        state_d = FIN;
                    end else begin
                        emitPtr_d = emitPtr_q + IDX_W'(1);
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            lastIssued_q <= 1'b0;
            emitPtr_q    <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            lastIssued_q <= lastIssued_d;
            emitPtr_q    <= emitPtr_d;
        end
    end

    // Record fields are forced to zero outside EMIT so idle outputs stay quiet.
    assign emitOn          = (state_q == EMIT) && rdEntry.vld;
    assign bus.res_valid   = (state_q == EMIT);
    assign bus.res_label   = emitOn ? rdEntry.label   : '0;
    assign bus.res_area    = emitOn ? rdEntry.area    : '0;
    assign bus.res_row_min = emitOn ? rdEntry.row_min : '0;
    assign bus.res_row_max = emitOn ? rdEntry.row_max : '0;
    assign bus.res_col_min = emitOn ? rdEntry.col_min : '0;
    assign bus.res_col_max = emitOn ? rdEntry.col_max : '0;

    assign bus.sram_a   = addr_q;
    assign bus.sram_wen = 1'b1;
    assign bus.sram_d   = '0;

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == FIN);
    assign obj_count = tblCount;
    assign overflow  = tblOverflow;

endmodule

// File: tb/tb_cle_label_reader.sv
// Testbench for cle_label_reader: directed images in a behavioural SRAM,
// expected records queued by the stimulus, checked by a separate monitor.
module tb_cle_label_reader;

    typedef struct packed {
        logic [7:0]  label;
        logic [10:0] area;
        logic [4:0]  rmin;
        logic [4:0]  rmax;
        logic [4:0]  cmin;
        logic [4:0]  cmax;
    } rec_t;

    logic       clk;
    logic       reset;
    logic       start;
    logic       busy;
    logic       done;
    logic [3:0] obj_count;
    logic       overflow;

    cle_label_reader_if bus();

    cle_label_reader dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .obj_count (obj_count),
        .overflow  (overflow),
        .bus       (bus)
    );

    logic [7:0] mem [1024];
    rec_t       expQ [$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         t0 = 0;
    int         expDoneCyc = 0;
    int         expCount = 0;
    int         expOvf = 0;
    bit         doneSeen = 0;
    bit         firstValidSeen = 0;

    // 100 MHz-style clock and a cycle counter used for latency checks
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous read-only SRAM with one cycle of latency
    always @(posedge clk) bus.sram_q <= mem[bus.sram_a];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops expected records on each transfer, checks hold-stability
    // while stalled, first-valid latency and the done-time statistics.
    rec_t curRec, prevRec, expRec;
    bit   prevValid, prevReady;
    always @(negedge clk) begin
        if (!reset) begin
            prevValid = 1'b0;
            prevReady = 1'b0;
            prevRec   = '0;
        end else begin
            curRec = '{bus.res_label, bus.res_area, bus.res_row_min, bus.res_row_max,
                       bus.res_col_min, bus.res_col_max};
            if (prevValid && !prevReady) begin
                checkOutput("stall valid held", 32'(bus.res_valid), 32'd1);
                checkOutput("stall record held", 32'(curRec == prevRec), 32'd1);
            end
            if (bus.res_valid && !firstValidSeen) begin
                firstValidSeen = 1'b1;
                checkOutput("first valid cycle", 32'(cyc - t0), 32'd1025);
            end
            if (bus.res_valid && bus.res_ready) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected record: got label %0h area %0d expected none",
                             curRec.label, curRec.area);
                end else begin
                    expRec = expQ.pop_front();
                    checks++;
                    if (curRec !== expRec) begin
                        errors++;
                        $display("[TB] FAIL record: got lbl %0h area %0d r %0d..%0d c %0d..%0d expected lbl %0h area %0d r %0d..%0d c %0d..%0d",
                                 curRec.label, curRec.area, curRec.rmin, curRec.rmax, curRec.cmin, curRec.cmax,
                                 expRec.label, expRec.area, expRec.rmin, expRec.rmax, expRec.cmin, expRec.cmax);
                    end
                end
            end
            if (done) begin
                doneSeen = 1'b1;
                checkOutput("done cycle", 32'(cyc - t0), 32'(expDoneCyc));
                checkOutput("obj_count at done", 32'(obj_count), 32'(expCount));
                checkOutput("overflow at done", 32'(overflow), 32'(expOvf));
                checkOutput("records left at done", 32'(expQ.size()), 32'd0);
            end
            prevValid = bus.res_valid;
            prevReady = bus.res_ready;
            prevRec   = curRec;
        end
    end

    task automatic clearMem();
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    endtask

    task automatic pushRec(input int lbl, input int area, input int rmin, input int rmax,
                           input int cmin, input int cmax);
        expQ.push_back('{8'(lbl), 11'(area), 5'(rmin), 5'(rmax), 5'(cmin), 5'(cmax)});
    endtask

    task automatic loadImage3();
        clearMem();
        mem[0] = 8'h07; mem[1] = 8'h07; mem[2] = 8'h07;
        mem[31] = 8'h03; mem[63] = 8'h03;
    endtask

    // Pulse start for one cycle; t0 marks the edge that samples it.
    task automatic applyStimulus();
        @(posedge clk); #1;
        start = 1'b1;
        firstValidSeen = 1'b0;
        doneSeen = 1'b0;
        @(posedge clk); #1;
        t0 = cyc;
        start = 1'b0;
    endtask

    task automatic waitDone(input string name);
        for (int i = 0; i < 3000 && !doneSeen; i++) @(posedge clk);
        #1;
        checkOutput(name, 32'(doneSeen), 32'd1);
    endtask

    task automatic waitAddr(input int a);
        int n;
        n = 0;
        while (bus.sram_a != 10'(a) && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("reach address", 32'(bus.sram_a), 32'(a));
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " busy"}, 32'(busy), 32'd0);
        checkOutput({tag, " done"}, 32'(done), 32'd0);
        checkOutput({tag, " obj_count"}, 32'(obj_count), 32'd0);
        checkOutput({tag, " overflow"}, 32'(overflow), 32'd0);
        checkOutput({tag, " sram_a"}, 32'(bus.sram_a), 32'd0);
        checkOutput({tag, " sram_wen"}, 32'(bus.sram_wen), 32'd1);
        checkOutput({tag, " sram_d"}, 32'(bus.sram_d), 32'd0);
        checkOutput({tag, " res_valid"}, 32'(bus.res_valid), 32'd0);
        checkOutput({tag, " res_label"}, 32'(bus.res_label), 32'd0);
        checkOutput({tag, " res_area"}, 32'(bus.res_area), 32'd0);
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b0;
        start = 1'b0;
        bus.res_ready = 1'b1;
        clearMem();
        repeat (3) @(posedge clk);
        #1;
        checkResetValues("reset");
        reset = 1'b1;

        // Empty image: done straight after the scan, no records
        $display("[TB] test 1: empty image");
        clearMem();
        expCount = 0; expOvf = 0;
        applyStimulus();
        expDoneCyc = 1025;
        waitDone("test1 done");

        // Single pixel at row 1, col 1
        $display("[TB] test 2: single pixel");
        clearMem();
        mem[33] = 8'h05;
        pushRec(5, 1, 1, 1, 1, 1);
        expCount = 1; expOvf = 0;
        applyStimulus();
        expDoneCyc = 1026;
        waitDone("test2 done");

        // Two objects, first-seen order
        $display("[TB] test 3: two objects");
        loadImage3();
        pushRec(7, 3, 0, 0, 0, 2);
        pushRec(3, 2, 0, 1, 31, 31);
        expCount = 2; expOvf = 0;
        applyStimulus();
        expDoneCyc = 1027;
        waitDone("test3 done");

        // Nine labels into an eight-entry table
        $display("[TB] test 4: overflow");
        clearMem();
        for (int i = 0; i < 9; i++) mem[i] = 8'(i + 1);
        for (int i = 0; i < 8; i++) pushRec(i + 1, 1, 0, 0, i, i);
        expCount = 8; expOvf = 1;
        applyStimulus();
        expDoneCyc = 1033;
        waitDone("test4 done");

        // Back-pressure: first record stalled for five cycles
        $display("[TB] test 5: back-pressure");
        loadImage3();
        pushRec(7, 3, 0, 0, 0, 2);
        pushRec(3, 2, 0, 1, 31, 31);
        expCount = 2; expOvf = 0;
        bus.res_ready = 1'b0;
        applyStimulus();
        expDoneCyc = 1032;
        for (int i = 0; i < 1100 && !bus.res_valid; i++) begin
            @(posedge clk); #1;
        end
        checkOutput("test5 valid appears", 32'(bus.res_valid), 32'd1);
        repeat (5) begin
            @(posedge clk); #1;
        end
        bus.res_ready = 1'b1;
        waitDone("test5 done");

        // Reset in the middle of a scan aborts everything
        $display("[TB] test 6a: reset mid-scan");
        loadImage3();
        expCount = 0; expOvf = 0;
        applyStimulus();
        waitAddr(500);
        reset = 1'b0;
        #1;
        checkResetValues("midscan reset");
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        checkOutput("no done after abort", 32'(doneSeen), 32'd0);
        checkOutput("idle after abort", 32'(busy), 32'd0);

        // Second start mid-scan is ignored; records match the first scan
        $display("[TB] test 6b: start while busy, rescan");
        loadImage3();
        pushRec(7, 3, 0, 0, 0, 2);
        pushRec(3, 2, 0, 1, 31, 31);
        expCount = 2; expOvf = 0;
        applyStimulus();
        expDoneCyc = 1027;
        waitAddr(300);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput("ignored start addr", 32'(bus.sram_a), 32'd301);
        checkOutput("ignored start busy", 32'(busy), 32'd1);
        waitDone("test6b done");

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
